custom_axi_ip_reg_top: RTL

CUSTOM_AXI_IP_REG_TOP -- requirements
Module: custom_axi_ip_reg_top

---
 rtl/custom_axi_ip_reg_pkg.sv | 58 +++++
 rtl/custom_axi_ip_reg_subreg.sv | 60 ++++++
 rtl/custom_axi_ip_reg_top.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/custom_axi_ip_reg_pkg.sv
// ---------------------------------------------------------------------------
// custom_axi_ip_reg_pkg
// Shared types and constants for the custom_axi_ip register block:
//   - reg2hw / hw2reg structs (per register: value + strobe/enable)
//   - register byte offsets and AXI response codes
//   - word-address decoder used by both the write and read paths
// ---------------------------------------------------------------------------
package custom_axi_ip_reg_pkg;

    localparam int unsigned NUM_REGS = 3;

    localparam logic [31:0] REG0_OFFSET = 32'h0000_0000;
    localparam logic [31:0] REG1_OFFSET = 32'h0000_0004;
    localparam logic [31:0] REG2_OFFSET = 32'h0000_0008;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SEL_REG0 = 2'd0,
        SEL_REG1 = 2'd1,
        SEL_REG2 = 2'd2,
        SEL_NONE = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [31:0] q;
        logic        de;
    } custom_axi_ip_reg2hw_reg_t;

    typedef struct packed {
        custom_axi_ip_reg2hw_reg_t reg2;
        custom_axi_ip_reg2hw_reg_t reg1;
        custom_axi_ip_reg2hw_reg_t reg0;
    } custom_axi_ip_reg2hw_t;

    typedef struct packed {
        logic [31:0] d;
        logic        de;
    } custom_axi_ip_hw2reg_reg_t;

    typedef struct packed {
        custom_axi_ip_hw2reg_reg_t reg2;
        custom_axi_ip_hw2reg_reg_t reg1;
        custom_axi_ip_hw2reg_reg_t reg0;
    } custom_axi_ip_hw2reg_t;

    // Decode a word address (byte address >> 2); sub-word bits never matter.
    function automatic reg_sel_e decode_word(input logic [29:0] word);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word == REG0_OFFSET[31:2]) sel = SEL_REG0;
        if (word == REG1_OFFSET[31:2]) sel = SEL_REG1;
        if (word == REG2_OFFSET[31:2]) sel = SEL_REG2;
        return sel;
    endfunction

endpackage

// File: rtl/custom_axi_ip_reg_subreg.sv
// ---------------------------------------------------------------------------
// custom_axi_ip_subreg
// One 32-bit RW register with byte-merged bus write and hardware update.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_we              bus write lands this cycle
//   i_wdata, i_wstrb  bus write data and byte strobes
//   i_hw_de, i_hw_d   hardware update enable and value
//   o_q               current register value
//   o_de              one-cycle pulse, high the cycle after a bus write
//                     (i.e. while o_q already shows the written value)
// A bus write wins over a simultaneous hardware update.
// ---------------------------------------------------------------------------
module custom_axi_ip_subreg
    import custom_axi_ip_reg_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic          i_hw_de,
    input  logic [DW-1:0] i_hw_d,
    output logic [DW-1:0] o_q,
    output logic          o_de
);

    logic [DW-1:0] r_q;
    logic          r_de;
    logic [DW-1:0] w_merged;

    always_comb begin
        w_merged = r_q;
        for (int unsigned i = 0; i < DW/8; i++) begin
            if (i_wstrb[i]) begin
                w_merged[i*8 +: 8] = i_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q  <= '0;
            r_de <= 1'b0;
        end else begin
            r_de <= i_we;
            if (i_we) begin
                r_q <= w_merged;
            end else if (i_hw_de) begin
                r_q <= i_hw_d;
            end
        end
    end

    assign o_q  = r_q;
    assign o_de = r_de;

endmodule

// File: rtl/custom_axi_ip_reg_top.sv
// ---------------------------------------------------------------------------
// custom_axi_ip_reg_top
// AXI4-Lite slave exposing REG0 (0x0), REG1 (0x4), REG2 (0x8).
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*        AXI4-Lite write address / data / response
//   s_ar*, s_r*              AXI4-Lite read address / data
//   reg2hw_o                 register values and bus-write strobes
//   hw2reg_i                 hardware update values and enables
// AW and W are each captured into a one-entry buffer; the write is
// performed the cycle after both are full. Reads have one cycle latency
// and return the value before any write landing on the same edge.
// ---------------------------------------------------------------------------
module custom_axi_ip_reg_top
    import custom_axi_ip_reg_pkg::*;
#(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AW-1:0]         s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DW-1:0]         s_wdata,
    input  logic [DW/8-1:0]       s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AW-1:0]         s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DW-1:0]         s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output custom_axi_ip_reg2hw_t reg2hw_o,
    input  custom_axi_ip_hw2reg_t hw2reg_i
);

    // Write buffers (only the word part of the address is kept)
    logic                r_aw_full;
    logic [AW-3:0]       r_aw_word;
    logic                r_w_full;
    logic [DW-1:0]       r_w_data;
    logic [DW/8-1:0]     r_w_strb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;

    // Read response
    logic                r_rvalid;
    logic [DW-1:0]       r_rdata;
    logic [1:0]          r_rresp;

    logic                w_write;
    reg_sel_e            w_aw_sel;
    reg_sel_e            w_ar_sel;
    logic [NUM_REGS-1:0] w_we;
    logic [NUM_REGS-1:0] w_hw_de;
    logic [NUM_REGS-1:0][DW-1:0] w_hw_d;
    logic [NUM_REGS-1:0][DW-1:0] w_q;
    logic [NUM_REGS-1:0] w_de;
    logic [DW-1:0]       w_rd_data;
    logic [1:0]          w_rd_resp;
    logic                w_unused_addr_bits;

    assign w_unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    assign s_awready = ~r_aw_full & ~r_bvalid;
    assign s_wready  = ~r_w_full  & ~r_bvalid;
    assign s_arready = ~r_rvalid;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

    assign w_write  = r_aw_full & r_w_full;
    assign w_aw_sel = decode_word(30'(r_aw_word));
    assign w_ar_sel = decode_word(30'(s_araddr[AW-1:2]));

    always_comb begin
        w_we = '0;
        if (w_write) begin
            case (w_aw_sel)
                SEL_REG0: w_we[0] = 1'b1;
                SEL_REG1: w_we[1] = 1'b1;
                SEL_REG2: w_we[2] = 1'b1;
                default:  w_we    = '0;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        case (w_ar_sel)
            SEL_REG0: begin w_rd_data = w_q[0]; w_rd_resp = RESP_OKAY; end
            SEL_REG1: begin w_rd_data = w_q[1]; w_rd_resp = RESP_OKAY; end
            SEL_REG2: begin w_rd_data = w_q[2]; w_rd_resp = RESP_OKAY; end
            default:  begin w_rd_data = '0;     w_rd_resp = RESP_SLVERR; end
        endcase
    end

    // Write channel: buffers fill independently; readies are low while full,
    // so a capture can never coincide with the write that empties them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_aw_full <= 1'b0;
            r_aw_word <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (s_awvalid && s_awready) begin
                r_aw_full <= 1'b1;
                r_aw_word <= s_awaddr[AW-1:2];
            end
            if (s_wvalid && s_wready) begin
                r_w_full <= 1'b1;
                r_w_data <= s_wdata;
                r_w_strb <= s_wstrb;
            end
            if (w_write) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= (w_aw_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (r_bvalid && s_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data captured from current storage, so a write landing
    // on the same edge is not visible to this read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (s_arvalid && s_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && s_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign w_hw_de = {hw2reg_i.reg2.de, hw2reg_i.reg1.de, hw2reg_i.reg0.de};
    assign w_hw_d  = {hw2reg_i.reg2.d,  hw2reg_i.reg1.d,  hw2reg_i.reg0.d};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        custom_axi_ip_subreg #(
            .DW (DW)
        ) u_subreg (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_we    (w_we[g]),
            .i_wdata (r_w_data),
            .i_wstrb (r_w_strb),
            .i_hw_de (w_hw_de[g]),
            .i_hw_d  (w_hw_d[g]),
            .o_q     (w_q[g]),
            .o_de    (w_de[g])
        );
    end

    assign reg2hw_o.reg0.q  = w_q[0];
    assign reg2hw_o.reg0.de = w_de[0];
    assign reg2hw_o.reg1.q  = w_q[1];
    assign reg2hw_o.reg1.de = w_de[1];
    assign reg2hw_o.reg2.q  = w_q[2];
    assign reg2hw_o.reg2.de = w_de[2];

endmodule
